// File: rtl/imm_pkg.sv
// imm_pkg: format selects, per-format field masks and defaults for imm_packer
package imm_pkg;

    localparam logic [2:0] SEL_I = 3'd0;
    localparam logic [2:0] SEL_S = 3'd1;
    localparam logic [2:0] SEL_B = 3'd2;
    localparam logic [2:0] SEL_J = 3'd3;
    localparam logic [2:0] SEL_U = 3'd4;

    localparam logic [31:0] MASK_I = 32'hFFF0_0000;
    localparam logic [31:0] MASK_S = 32'hFE00_0F80;
    localparam logic [31:0] MASK_B = 32'hFE00_0F80;
    localparam logic [31:0] MASK_J = 32'hFFFF_F000;
    localparam logic [31:0] MASK_U = 32'hFFFF_F000;

    localparam int ERRW_DEF = 16;

    // Illegal selects get an empty mask so the base word passes through untouched.
    function automatic logic [31:0] sel_mask(input logic [2:0] sel);
        return (sel == SEL_I) ? MASK_I :
               (sel == SEL_S) ? MASK_S :
               (sel == SEL_B) ? MASK_B :
               (sel == SEL_J) ? MASK_J :
               (sel == SEL_U) ? MASK_U : 32'h0;
    endfunction

endpackage

// File: rtl/imm_scatter.sv
// imm_scatter: places an immediate into its format's instruction bits and flags
// illegal selects; with IMM_RANGE_CHECK_EN it also flags unrepresentable immediates.
module imm_scatter
    import imm_pkg::*;
(
    input  logic [2:0]  i_sel,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_base,
    output logic [31:0] o_instr,
    output logic        o_err
);

    logic [31:0] w_field;
    logic        w_illegal;
    logic        w_range_err;

    // Per-format bit placement; immediate bits with no home are dropped.
    always_comb begin
        w_field   = '0;
        w_illegal = 1'b0;
        case (i_sel)
            SEL_I:   w_field = {i_imm[11:0], 20'b0};
            SEL_S:   w_field = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
            SEL_B:   w_field = {i_imm[12], i_imm[10:5], 13'b0, i_imm[4:1], i_imm[11], 7'b0};
            SEL_J:   w_field = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'b0};
            SEL_U:   w_field = {i_imm[31:12], 12'b0};
            default: w_illegal = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // A value fits when all bits above the format's sign bit repeat it.
    always_comb begin
        w_range_err = 1'b0;
        case (i_sel)
            SEL_I, SEL_S: w_range_err = ~(&i_imm[31:11] | ~|i_imm[31:11]);
            SEL_B:        w_range_err = ~(&i_imm[31:12] | ~|i_imm[31:12]) | i_imm[0];
            SEL_J:        w_range_err = ~(&i_imm[31:20] | ~|i_imm[31:20]) | i_imm[0];
            SEL_U:        w_range_err = |i_imm[11:0];
            default:      w_range_err = 1'b0;
        endcase
    end
`else
    assign w_range_err = 1'b0;
`endif

    assign o_instr = (i_base & ~sel_mask(i_sel)) | w_field;
    assign o_err   = w_illegal | w_range_err;

endmodule

// File: rtl/imm_packer.sv
// imm_packer: packs immediates into base instruction words and emits them through a
// 2-entry valid/ready buffer; optional range checking via IMM_RANGE_CHECK_EN.
module imm_packer
    import imm_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ERRW  = ERRW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_base,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [2:0]       in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic             out_err,
    output logic [ERRW-1:0]  err_count
);

    logic [WIDTH-1:0] r_head_instr;
    logic [WIDTH-1:0] r_tail_instr;
    logic             r_head_err;
    logic             r_tail_err;
    logic [1:0]       r_occ;
    logic [ERRW-1:0]  r_err_count;
    logic [WIDTH-1:0] w_instr;
    logic             w_err;
    logic             w_push;
    logic             w_pop;

    imm_scatter u_scatter (
        .i_sel   (in_sel),
        .i_imm   (in_imm),
        .i_base  (in_base),
        .o_instr (w_instr),
        .o_err   (w_err)
    );

    assign in_ready  = (r_occ != 2'd2);
    assign out_valid = (r_occ != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign out_instr = r_head_instr;
    assign out_err   = r_head_err;
    assign err_count = r_err_count;

    // Occupancy: a push and a pop on the same edge cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= 2'd0;
        end else begin
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Head takes the new word when the buffer is or becomes empty, else promotes the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_instr <= '0;
            r_head_err   <= 1'b0;
        end else if (w_push && (r_occ == 2'd0 || (r_occ == 2'd1 && w_pop))) begin
            r_head_instr <= w_instr;
            r_head_err   <= w_err;
        end else if (w_pop && r_occ == 2'd2) begin
            r_head_instr <= r_tail_instr;
            r_head_err   <= r_tail_err;
        end
    end

    // Tail fills only when a word arrives behind a head that is staying.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tail_instr <= '0;
            r_tail_err   <= 1'b0;
        end else if (w_push && r_occ == 2'd1 && !w_pop) begin
            r_tail_instr <= w_instr;
            r_tail_err   <= w_err;
        end
    end

    // Saturating count of accepted words carrying the error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_push && w_err && !(&r_err_count)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_packer.sv
// tb_imm_packer: directed and randomized checks of imm_packer against a behavioural model
`timescale 1ns/1ps
module tb_imm_packer;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_base = '0;
    logic [31:0] in_imm = '0;
    logic [2:0]  in_sel = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        int          c;
    } ent_t;

    ent_t        mq[$];
    ent_t        lq[$];
    logic [15:0] m_errs = '0;

    imm_packer #(.WIDTH(32), .ERRW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_base   (in_base),
        .in_imm    (in_imm),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: field placement by shifts/masks, range by signed value limits.
    function automatic logic [31:0] m_pack(input logic [31:0] b, input logic [31:0] v,
                                           input int s, output logic e);
        int          sv;
        logic [31:0] m;
        logic [31:0] f;
        sv = $signed(v);
        m  = 32'h0;
        f  = 32'h0;
        e  = 1'b0;
        case (s)
            0: begin
                m = 32'hFFF0_0000;
                f = (v & 32'hFFF) << 20;
                e = RC && (sv < -2048 || sv > 2047);
            end
            1: begin
                m = 32'hFE00_0F80;
                f = (((v >> 5) & 32'h7F) << 25) | ((v & 32'h1F) << 7);
                e = RC && (sv < -2048 || sv > 2047);
            end
            2: begin
                m = 32'hFE00_0F80;
                f = (((v >> 12) & 32'd1) << 31) | (((v >> 5) & 32'h3F) << 25) |
                    (((v >> 1) & 32'hF) << 8) | (((v >> 11) & 32'd1) << 7);
                e = RC && (sv < -4096 || sv > 4095 || v[0]);
            end
            3: begin
                m = 32'hFFFF_F000;
                f = (((v >> 20) & 32'd1) << 31) | (((v >> 1) & 32'h3FF) << 21) |
                    (((v >> 11) & 32'd1) << 20) | (((v >> 12) & 32'hFF) << 12);
                e = RC && (sv < -(1 << 20) || sv > (1 << 20) - 1 || v[0]);
            end
            4: begin
                m = 32'hFFFF_F000;
                f = v & 32'hFFFF_F000;
                e = RC && ((v & 32'hFFF) != 32'h0);
            end
            default: e = 1'b1;
        endcase
        return (b & ~m) | f;
    endfunction

    // Reference FIFO: pop the head, then append an accepted word.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_errs = '0;
        end else begin
            bit   acc;
            ent_t e;
            acc = in_valid && (mq.size() < 2);
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (acc) begin
                e.instr = m_pack(in_base, in_imm, int'(in_sel), e.err);
                e.c     = 0;
                mq.push_back(e);
                if (e.err && m_errs != 16'hFFFF) m_errs = m_errs + 16'd1;
            end
        end
    end

    // Per-cycle compare against the model, or against reset values while in reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", {31'b0, out_valid}, 32'd0);
            check("rst_out_instr", out_instr, 32'd0);
            check("rst_out_err", {31'b0, out_err}, 32'd0);
            check("rst_err_count", {16'b0, err_count}, 32'd0);
            check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        end else begin
            check("in_ready", {31'b0, in_ready}, {31'b0, mq.size() < 2});
            check("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
            check("err_count", {16'b0, err_count}, {16'b0, m_errs});
            if (mq.size() != 0) begin
                check("out_instr", out_instr, mq[0].instr);
                check("out_err", {31'b0, out_err}, {31'b0, mq[0].err});
            end
        end
    end

    // Log of words actually delivered, for directed order/latency checks.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) lq.push_back('{out_instr, out_err, cyc});
    end

    function automatic ent_t lq_at(input int i);
        ent_t z;
        z = '{32'h0, 1'b0, -1};
        return (i < lq.size()) ? lq[i] : z;
    endfunction

    task automatic send(input logic [31:0] b, input logic [31:0] v, input logic [2:0] s,
                        output int acc_cyc);
        in_valid = 1'b1;
        in_base  = b;
        in_imm   = v;
        in_sel   = s;
        acc_cyc  = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (acc_cyc < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   c0;
        int   cs[4];
        logic e;
        ent_t x;

        check("pin_I", m_pack(32'h13, 32'hFFFF_FFFF, 0, e), 32'hFFF0_0013);
        check("pin_S", m_pack(32'h2023, 32'h7FF, 1, e), 32'h7E00_2FA3);
        check("pin_B", m_pack(32'h63, 32'hFFFF_FFFC, 2, e), 32'hFE00_0EE3);
        check("pin_J", m_pack(32'hEF, 32'd8, 3, e), 32'h0080_00EF);
        check("pin_U", m_pack(32'hB7, 32'h1234_5000, 4, e), 32'h1234_50B7);
        check("pin_ill", m_pack(32'h1234_5678, 32'hFFFF, 6, e), 32'h1234_5678);
        check("pin_ill_err", {31'b0, e}, 32'd1);

        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(1);

        out_ready = 1'b1;
        send(32'h13, 32'hFFFF_FFFF, 3'd0, c0);
        idle();
        wait_cycles(3);
        x = lq_at(0);
        check("I_count", lq.size(), 32'd1);
        check("I_instr", x.instr, 32'hFFF0_0013);
        check("I_err", {31'b0, x.err}, 32'd0);
        check("I_latency", x.c, c0);

        lq.delete();
        send(32'h2023, 32'h7FF, 3'd1, cs[0]);
        send(32'h63, 32'hFFFF_FFFC, 3'd2, cs[1]);
        send(32'hEF, 32'd8, 3'd3, cs[2]);
        send(32'hB7, 32'h1234_5000, 3'd4, cs[3]);
        idle();
        wait_cycles(3);
        check("SBJU_count", lq.size(), 32'd4);
        check("S_instr", lq_at(0).instr, 32'h7E00_2FA3);
        check("B_instr", lq_at(1).instr, 32'hFE00_0EE3);
        check("J_instr", lq_at(2).instr, 32'h0080_00EF);
        check("U_instr", lq_at(3).instr, 32'h1234_50B7);
        for (int i = 0; i < 4; i++) begin
            check("SBJU_err", {31'b0, lq_at(i).err}, 32'd0);
            check("SBJU_rate", cs[i], cs[0] + i);
            check("SBJU_latency", lq_at(i).c, cs[i]);
        end

        lq.delete();
        send(32'h13, 32'h800, 3'd0, c0);
        idle();
        wait_cycles(2);
        check("rng_I_instr", lq_at(0).instr, 32'h8000_0013);
        check("rng_I_err", {31'b0, lq_at(0).err}, {31'b0, RC});
        check("rng_I_cnt", {16'b0, err_count}, RC ? 32'd1 : 32'd0);
        send(32'h63, 32'd3, 3'd2, c0);
        idle();
        wait_cycles(2);
        check("rng_B_instr", lq_at(1).instr, 32'h0000_0163);
        check("rng_B_err", {31'b0, lq_at(1).err}, {31'b0, RC});
        send(32'h1234_5678, 32'hDEAD_BEEF, 3'd6, c0);
        idle();
        wait_cycles(2);
        check("ill_instr", lq_at(2).instr, 32'h1234_5678);
        check("ill_err", {31'b0, lq_at(2).err}, 32'd1);
        check("ill_cnt", {16'b0, err_count}, RC ? 32'd3 : 32'd1);

        lq.delete();
        out_ready = 1'b0;
        send(32'h13, 32'd1, 3'd0, c0);
        send(32'h13, 32'd2, 3'd0, c0);
        in_base = 32'h13;
        in_imm  = 32'd3;
        in_sel  = 3'd0;
        wait_cycles(2);
        @(negedge clk);
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        check("bp_out_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h13, 32'd3, 3'd0, c0);
        idle();
        wait_cycles(4);
        check("bp_count", lq.size(), 32'd3);
        check("bp_w0", lq_at(0).instr, 32'h0010_0013);
        check("bp_w1", lq_at(1).instr, 32'h0020_0013);
        check("bp_w2", lq_at(2).instr, 32'h0030_0013);

        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(1);
        out_ready = 1'b0;
        send(32'hAAAA_5555, 32'h0, 3'd7, c0);
        send(32'h0F0F_0F0F, 32'h0, 3'd5, c0);
        idle();
        @(negedge clk);
        check("mid_cnt", {16'b0, err_count}, 32'd2);
        check("mid_full", {31'b0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        lq.delete();
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_out_instr", out_instr, 32'd0);
        check("arst_out_err", {31'b0, out_err}, 32'd0);
        check("arst_err_count", {16'b0, err_count}, 32'd0);
        check("arst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        wait_cycles(5);
        check("post_rst_valid", {31'b0, out_valid}, 32'd0);
        check("post_rst_none", lq.size(), 32'd0);

        for (int i = 0; i < 800; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            in_base   = $urandom;
            in_sel    = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: in_imm = $urandom;
                1: in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: in_imm = $urandom & 32'hFFFF_F000;
                default: in_imm = (32'($urandom_range(0, 1)) ? 32'hFFF0_0000 : 32'h0) |
                                  ($urandom & 32'h001F_FFFE);
            endcase
            @(posedge clk);
            #1;
        end
        idle();
        out_ready = 1'b1;
        wait_cycles(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_packer.md
# imm_packer

Streaming RISC-V immediate packer: the inverse of the instruction-side immediate generator. It takes a base instruction word (opcode, registers and funct fields already placed), a 32-bit immediate value and a format select. It scatters the immediate into the format's instruction bit positions, optionally range-checks it, and emits the finished instruction word through a 2-entry valid/ready output buffer. It sits between the assembler/loader front end and the instruction-memory writer.

## Interface
Parameters:
- WIDTH, 32, instruction and immediate width; only 32 is supported.
- ERRW, 16, width of the saturating error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  packer can accept; a transfer happens on `in_valid & in_ready` at a clk edge.
- in_base  in  WIDTH  instruction with non-immediate fields set; its immediate bits are ignored.
- in_imm  in  WIDTH  immediate value, two's complement.
- in_sel  in  3  format: 0 I, 1 S, 2 B, 3 J (jal), 4 U (lui/auipc), 5-7 illegal.
- out_valid  out  1  output word present.
- out_ready  in  1  consumer accepts; a transfer happens on `out_valid & out_ready`.
- out_instr  out  WIDTH  packed instruction.
- out_err  out  1  the word at the buffer head had an illegal select or an out-of-range immediate.
- err_count  out  ERRW  saturating count of accepted words with the error flag set.

## Operation
- Packed word = (in_base & ~MASK[sel]) | SCATTER(sel, in_imm).
- Field placement:
  - I: imm[11:0] goes to bits 31:20.
  - S: imm[11:5] goes to 31:25; imm[4:0] goes to 11:7.
  - B: imm[12] goes to 31; imm[10:5] to 30:25; imm[4:1] to 11:8; imm[11] to 7.
  - J: imm[20] goes to 31; imm[10:1] to 30:21; imm[11] to 20; imm[19:12] to 19:12.
  - U: imm[31:12] goes to 31:12.
- Masks:
  - I: 31:20.
  - S and B: 31:25 and 11:7.
  - J and U: 31:12.
- Illegal select (5-7): in_base passes through unchanged and the error flag is set.
- Immediate bits not placed are dropped (truncation).
- Error flag and output word are computed when the input is accepted and travel with the word through the buffer.
- err_count increments on each accepted word with the error flag set and saturates at all-ones.
- Output buffer:
  - 2-entry FIFO with head at out_instr/out_err.
  - Order is preserved.
  - Contents are not modified while held.

## Timing
- Reset (async assert, sync release): out_valid=0, out_instr=0, out_err=0, err_count=0, buffer empty, in_ready=1.
- Latency: a word accepted at edge N is visible on out_valid/out_instr after edge N when the buffer was empty. Otherwise it appears behind the older entries.
- in_ready = (occupancy < 2). It is derived from registered occupancy only, with no combinational path from out_ready.
- Occupancy 1 with push and pop on the same edge: occupancy stays 1 and the new word becomes the head.
- Occupancy 2: no push is accepted; a pop returns occupancy to 1.
- Occupancy 0: out_valid=0 and out_ready is ignored.
- Sustained throughput is 1 word/cycle while out_ready=1.
- Reset mid-stream discards all buffered words and clears err_count; nothing is emitted after reset until a new word is accepted.

## Configuration
- IMM_RANGE_CHECK_EN defined: the error flag is also set when the immediate is not representable in the selected format. Conditions per format:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0] ≠ 0.
- The word is still packed by truncation.
- IMM_RANGE_CHECK_EN undefined: no range logic is built; the error flag reflects only an illegal select.

## Structure
- Package imm_pkg holds:
  - format select localparams (SEL_I, SEL_S, SEL_B, SEL_J, SEL_U);
  - the per-format 32-bit MASK constants;
  - the ERRW default.
- One combinational sub-module, imm_scatter (sel, imm, base → instr, err), holds the placement and range check.
- The top holds the 2-entry buffer, occupancy counter and error counter.

## Test plan
- I: base 0x00000013, imm 0xFFFFFFFF, sel 0 → out_instr 0xFFF00013, out_err 0, one cycle after accept.
- S, B, J, U back-to-back with out_ready=1, all with out_err 0 and one word per cycle:
  - S: base 0x00002023, imm 0x7FF, sel 1 → 0x7E002FA3.
  - B: base 0x00000063, imm 0xFFFFFFFC, sel 2 → 0xFE000EE3.
  - J: base 0x000000EF, imm 8, sel 3 → 0x008000EF.
  - U: base 0x000000B7, imm 0x12345000, sel 4 → 0x123450B7.
- Errors, with IMM_RANGE_CHECK_EN defined:
  - sel 0, imm 0x800 → 0x80000013 with out_err 1 and err_count 1.
  - sel 2, imm 3 → out_err 1.
  - sel 6 → base unchanged, out_err 1, err_count 3.
  - With the macro undefined, only the sel 6 case flags.
- Backpressure: hold out_ready=0 and offer 3 words → in_ready drops after 2 are accepted. Raising out_ready drains the words in order and the third is then accepted; no word is lost or duplicated.
- Simultaneous push/pop at occupancy 1 → occupancy stays 1 and the head advances correctly.
- Pull rst_n low with 2 words buffered and err_count=2 → outputs reach reset values immediately. After release, out_valid stays 0 until a new accept.
